cfg_initiator: RTL and testbench



---
 rtl/cfg_initiator_pkg.sv | 28 ++
 rtl/cfg_req_buffer.sv | 46 ++++
 rtl/cfg_initiator.sv | 150 +++++++++++++++
 tb/tb_cfg_initiator.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_initiator_pkg.sv
// Shared widths, resolution codes and FSM encoding for the VGA config initiator.
// Resolution codes match the VGA_Control receiver.
package cfg_initiator_pkg;

  localparam int CONFIG_WIDTH = 2;
  localparam logic [CONFIG_WIDTH-1:0] VGA_ADDR = 2'b10;

  localparam logic [CONFIG_WIDTH-1:0] R6X4  = 2'd0;
  localparam logic [CONFIG_WIDTH-1:0] R8X6  = 2'd1;
  localparam logic [CONFIG_WIDTH-1:0] R10X7 = 2'd2;
  localparam int NUM_MODES = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRIVE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } cfg_state_e;

  typedef enum logic {
    REQ_SET  = 1'b0,
    REQ_NEXT = 1'b1
  } req_kind_e;

  function automatic logic [CONFIG_WIDTH-1:0] next_mode(input logic [CONFIG_WIDTH-1:0] cur);
    return (cur == CONFIG_WIDTH'(NUM_MODES - 1)) ? '0 : cur + CONFIG_WIDTH'(1);
  endfunction

endpackage

// File: rtl/cfg_req_buffer.sv
// Request decode plus a one-entry, latest-wins request buffer.
// Next requests are resolved against cur_mode when dispatched, not when captured.
module cfg_req_buffer
  import cfg_initiator_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_req,
  input  logic                    next_req,
  input  logic [CONFIG_WIDTH-1:0] set_mode,
  input  logic [CONFIG_WIDTH-1:0] cur_mode,
  input  logic                    store,
  input  logic                    pop,
  output logic                    req_valid,
  output logic                    req_invalid,
  output logic [CONFIG_WIDTH-1:0] req_target,
  output logic                    buf_valid,
  output logic [CONFIG_WIDTH-1:0] buf_target
);

  req_kind_e               kind_q;
  logic [CONFIG_WIDTH-1:0] mode_q;
  logic                    mode_ok;

  // Set has priority over Next, even when its mode is out of range.
  assign mode_ok     = set_mode < CONFIG_WIDTH'(NUM_MODES);
  assign req_invalid = set_req && !mode_ok;
  assign req_valid   = set_req ? mode_ok : next_req;
  assign req_target  = set_req ? set_mode : next_mode(cur_mode);
  assign buf_target  = (kind_q == REQ_SET) ? mode_q : next_mode(cur_mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      kind_q    <= REQ_NEXT;
      mode_q    <= '0;
    end else if (store) begin
      buf_valid <= 1'b1;
      kind_q    <= set_req ? REQ_SET : REQ_NEXT;
      mode_q    <= set_mode;
    end else if (pop) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cfg_initiator.sv
// Config-bus master for VGA_Control: single-cycle register writes with ack
// timeout, bounded retry and a one-entry request buffer.
//
// state       | meaning
// ST_IDLE     | no transaction; dispatch buffered entry first, else a new request
// ST_DRIVE    | one-cycle write strobe on the config bus
// ST_WAIT_ACK | waiting for C_rdy; timeout leads to retry or Error
module cfg_initiator
  import cfg_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_WIDTH  = 5,
  parameter int MAX_RETRY      = 3,
  parameter int RETRY_WIDTH    = 2
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Next_req,
  input  logic                    Set_req,
  input  logic [CONFIG_WIDTH-1:0] Set_mode,
  input  logic                    C_rdy,
  output logic                    C_valid,
  output logic [CONFIG_WIDTH-1:0] C_addr,
  output logic [CONFIG_WIDTH-1:0] C_data,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error,
  output logic [CONFIG_WIDTH-1:0] Cur_mode
);

  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_WIDTH-1:0]   RETRY_MAX = RETRY_WIDTH'(MAX_RETRY);

  cfg_state_e               state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic [RETRY_WIDTH-1:0]   retry_q, retry_d;
  logic                     c_valid_d, busy_d, done_d, error_d;
  logic [CONFIG_WIDTH-1:0]  c_addr_d, c_data_d, cur_mode_d;

  logic                     req_valid, req_invalid, buf_valid, store, pop, buf_pending;
  logic [CONFIG_WIDTH-1:0]  req_target, buf_target;

  cfg_req_buffer u_req_buffer (
    .clk        (Clk),
    .rst        (Rst),
    .set_req    (Set_req),
    .next_req   (Next_req),
    .set_mode   (Set_mode),
    .cur_mode   (Cur_mode),
    .store      (store),
    .pop        (pop),
    .req_valid  (req_valid),
    .req_invalid(req_invalid),
    .req_target (req_target),
    .buf_valid  (buf_valid),
    .buf_target (buf_target)
  );

  // A request is buffered unless it can be dispatched directly from an empty IDLE.
  assign store       = req_valid && ((state_q != ST_IDLE) || buf_valid);
  assign pop         = (state_q == ST_IDLE) && buf_valid;
  assign buf_pending = store || buf_valid;

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    retry_d    = retry_q;
    c_valid_d  = 1'b0;
    c_addr_d   = '0;
    c_data_d   = C_data;
    busy_d     = Busy;
    done_d     = 1'b0;
    error_d    = req_invalid;
    cur_mode_d = Cur_mode;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (buf_valid || req_valid) begin
          state_d   = ST_DRIVE;
          c_valid_d = 1'b1;
          c_addr_d  = VGA_ADDR;
          c_data_d  = buf_valid ? buf_target : req_target;
          busy_d    = 1'b1;
          tmo_d     = '0;
          retry_d   = '0;
        end
      end
      ST_DRIVE: begin
        // C_rdy here is a stale or post-reset Load and is ignored.
        state_d = ST_WAIT_ACK;
        busy_d  = 1'b1;
      end
      ST_WAIT_ACK: begin
        if (C_rdy) begin
          state_d    = ST_IDLE;
          cur_mode_d = C_data;
          done_d     = 1'b1;
          retry_d    = '0;
          busy_d     = buf_pending;
        end else if (tmo_q == TMO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            state_d   = ST_DRIVE;
            c_valid_d = 1'b1;
            c_addr_d  = VGA_ADDR;
            retry_d   = retry_q + RETRY_WIDTH'(1);
            tmo_d     = '0;
          end else begin
            state_d = ST_IDLE;
            error_d = 1'b1;
            busy_d  = buf_pending;
          end
        end else begin
          tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      tmo_q    <= '0;
      retry_q  <= '0;
      C_valid  <= 1'b0;
      C_addr   <= '0;
      C_data   <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Error    <= 1'b0;
      Cur_mode <= R6X4;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      retry_q  <= retry_d;
      C_valid  <= c_valid_d;
      C_addr   <= c_addr_d;
      C_data   <= c_data_d;
      Busy     <= busy_d;
      Done     <= done_d;
      Error    <= error_d;
      Cur_mode <= cur_mode_d;
    end
  end

endmodule

// File: tb/tb_cfg_initiator.sv
// Bench for cfg_initiator: directed scenarios plus randomized transactions,
// checked against a transaction-level model of the resolution rules.
module tb_cfg_initiator;

  localparam int TMO = 16;
  localparam int NM  = 3;

  logic       Clk = 1'b0;
  logic       Rst, Next_req, Set_req, C_rdy;
  logic [1:0] Set_mode;
  logic       C_valid, Busy, Done, Error;
  logic [1:0] C_addr, C_data, Cur_mode;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int m_cur = 0;

  int inj_n = 0;
  bit inj_set[4];
  bit inj_next[4];
  int inj_mode[4];
  bit rdy_drive = 0;

  int s_valid, s_done, s_err, s_bad, s_gap, s_lat;
  logic s_fin, s_err_end, s_busy_end;

  cfg_initiator dut (
    .Clk(Clk), .Rst(Rst), .Next_req(Next_req), .Set_req(Set_req), .Set_mode(Set_mode),
    .C_rdy(C_rdy), .C_valid(C_valid), .C_addr(C_addr), .C_data(C_data), .Busy(Busy),
    .Done(Done), .Error(Error), .Cur_mode(Cur_mode)
  );

  initial forever #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_c_valid"}, C_valid, 0);
    check({tag, "_c_addr"}, C_addr, 0);
    check({tag, "_c_data"}, C_data, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_error"}, Error, 0);
    check({tag, "_cur_mode"}, Cur_mode, 0);
  endtask

  // Acts as VGA_Control: acks attempt ack_att (0 = never) in WAIT_ACK cycle
  // ack_dly, and injects the queued requests during the first attempt.
  task automatic serve(input int ack_att, input int ack_dly, input int tgt);
    int att, widx, last_v;
    att = 0; widx = -1; last_v = 0;
    s_valid = 0; s_done = 0; s_err = 0; s_bad = 0; s_gap = 0; s_lat = 0;
    s_fin = 0; s_err_end = 0; s_busy_end = 0;
    for (int cyc = 0; cyc < 200 && s_fin == 1'b0; cyc++) begin
      step();
      C_rdy = 0; Set_req = 0; Next_req = 0;
      if (C_valid === 1'b1) begin
        att++; s_valid++;
        if (C_addr !== 2'b10 || C_data !== 2'(tgt) || Busy !== 1'b1) s_bad++;
        if (att > 1 && cyc - last_v != TMO + 1) s_gap++;
        last_v = cyc; widx = 0;
        if (rdy_drive) C_rdy = 1;
      end else if (Done === 1'b1) begin
        s_fin = 1; s_done++; s_busy_end = Busy; s_lat = cyc - last_v;
      end else if (widx >= TMO) begin
        s_fin = 1; s_busy_end = Busy; s_err_end = Error;
      end else if (widx >= 0) begin
        if (C_addr !== 2'b00 || C_data !== 2'(tgt) || Busy !== 1'b1) s_bad++;
        if (att == 1 && widx < inj_n) begin
          Set_req = inj_set[widx]; Next_req = inj_next[widx]; Set_mode = 2'(inj_mode[widx]);
        end
        if (att == ack_att && widx == ack_dly) C_rdy = 1;
        widx++;
      end
      if (Error === 1'b1 && s_fin == 1'b0) s_err++;
    end
    check("serve_bound", s_fin, 1);
  endtask

  task automatic rand_inj(input int n);
    int k;
    inj_n = n;
    for (int j = 0; j < n; j++) begin
      k = $urandom_range(0, 3);
      inj_set[j]  = (k != 0);
      inj_next[j] = (k == 0) || (k == 3);
      inj_mode[j] = (k == 2) ? 3 : $urandom_range(0, NM - 1);
    end
  endtask

  task automatic run_txn(input bit s, input bit n, input int mode, input int att,
                         input int dly, input bit rdrv);
    int tgt, tgt2, perr, pmode, d;
    bit pend, pset;
    Set_req = s; Next_req = n; Set_mode = 2'(mode);
    if (s && mode >= NM) begin
      inj_n = 0;
      step();
      Set_req = 0; Next_req = 0;
      check("inv_error", Error, 1);
      check("inv_no_valid", C_valid, 0);
      step();
      check("inv_error_width", Error, 0);
      check("inv_still_idle", C_valid | Busy, 0);
      check("inv_cur_mode", Cur_mode, m_cur);
      return;
    end
    tgt = s ? mode : (m_cur + 1) % NM;
    pend = 0; pset = 0; pmode = 0; perr = 0;
    for (int j = 0; j < inj_n; j++) begin
      if (inj_set[j]) begin
        if (inj_mode[j] >= NM) perr++;
        else begin pend = 1; pset = 1; pmode = inj_mode[j]; end
      end else if (inj_next[j]) begin
        pend = 1; pset = 0;
      end
    end
    d = (att == 1 && dly < inj_n) ? inj_n : dly;
    rdy_drive = rdrv;
    serve(att, d, tgt);
    check("attempts", s_valid, (att == 0) ? 4 : att);
    check("done_count", s_done, (att != 0) ? 1 : 0);
    check("retry_error", s_err_end, (att == 0) ? 1 : 0);
    check("bus_fields", s_bad, 0);
    check("retry_gap", s_gap, 0);
    check("capture_error", s_err, perr);
    check("busy_end", s_busy_end, pend);
    if (att != 0) begin
      check("ack_latency", s_lat, d + 2);
      m_cur = tgt;
    end
    check("cur_mode", Cur_mode, m_cur);
    if (pend) begin
      tgt2 = pset ? pmode : (m_cur + 1) % NM;
      inj_n = 0; rdy_drive = 0;
      d = $urandom_range(0, TMO - 1);
      serve(1, d, tgt2);
      check("buf_attempts", s_valid, 1);
      check("buf_done", s_done, 1);
      check("buf_bus_fields", s_bad, 0);
      check("buf_busy_end", s_busy_end, 0);
      check("buf_latency", s_lat, d + 2);
      m_cur = tgt2;
      check("buf_cur_mode", Cur_mode, m_cur);
    end
    rdy_drive = 0; inj_n = 0;
    step();
    check("post_quiet", {C_valid, Busy, Done, Error}, 4'b0000);
  endtask

  initial begin
    int k, mode, att, dly;
    bit s, n;
    Rst = 1; Next_req = 0; Set_req = 0; Set_mode = 0; C_rdy = 0;
    repeat (3) step();
    check_reset_outputs("reset");
    Rst = 0;
    step();
    check_reset_outputs("after_reset");

    // First Next from reset, immediate ack.
    run_txn(0, 1, 0, 1, 0, 0);
    // Wrap 2 -> 0.
    run_txn(1, 0, 2, 1, 3, 0);
    run_txn(0, 1, 0, 1, 0, 0);
    // Out-of-range Set, also with Next high.
    run_txn(1, 0, 3, 1, 0, 0);
    run_txn(1, 1, 3, 1, 0, 0);
    // No ack at all, then ack on the third attempt, then ack on the expiry cycle.
    run_txn(0, 1, 0, 0, 0, 0);
    run_txn(0, 1, 0, 3, 5, 0);
    run_txn(1, 0, 0, 2, TMO - 1, 0);
    // Set(2) then Next while waiting: Next is kept and resolved after the ack.
    inj_n = 2;
    inj_set[0] = 1; inj_next[0] = 0; inj_mode[0] = 2;
    inj_set[1] = 0; inj_next[1] = 1; inj_mode[1] = 0;
    run_txn(0, 1, 0, 1, 2, 0);
    // Set and Next together, C_rdy high during DRIVE.
    run_txn(1, 0, 0, 1, 0, 0);
    run_txn(1, 1, 1, 1, 2, 1);
    run_txn(1, 1, 2, 1, 0, 1);

    // Reset during WAIT_ACK with C_rdy asserted.
    Next_req = 1;
    step();
    Next_req = 0;
    check("pre_reset_valid", C_valid, 1);
    step();
    Rst = 1; C_rdy = 1;
    step();
    Rst = 0; C_rdy = 0;
    check_reset_outputs("mid_reset");
    step();
    check("mid_reset_quiet", {C_valid, Busy, Done, Error}, 4'b0000);
    m_cur = 0;
    run_txn(0, 1, 0, 1, 0, 0);

    for (int t = 0; t < 30; t++) begin
      k = $urandom_range(0, 9);
      s = (k >= 4);
      n = (k < 4) || (k >= 8);
      mode = $urandom_range(0, 3);
      att = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : 1;
      dly = $urandom_range(0, TMO - 1);
      rand_inj($urandom_range(0, 3));
      run_txn(s, n, mode, att, dly, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
